cmd_dispatcher: RTL
===================

// Module: cmd_dispatcher
//
// PURPOSE
// - Consumer (read side) of the 80-bit command FIFO that the EBI front end fills.
// - Pops one command at a time and decodes its fields.
// - Holds each command until global_clock reaches its start time, then issues it
//   on the internal control bus with a valid/ack handshake.
// - Reports errors through sticky flags and a delivered-command counter.
//
// PARAMETERS
// ACK_TIMEOUT  1024  cycles to wait for bus_ack in ISSUE; 0 disables the timeout
// CNT_W        16    width of issued_count
//
// PORTS
// clk                clk   1    system clock
// rst                in    1    synchronous reset, active-high
// global_clock       in    32   time base from the EBI block
// cmd_fifo_data_out  in    80   FIFO read data, valid the cycle after cmd_fifo_rd_en
// cmd_fifo_empty     in    1    FIFO empty
// cmd_fifo_rd_en     out   1    FIFO pop strobe, one-cycle pulse
// flush              in    1    abort the pending command and return to IDLE
// bus_addr           out   8    target unit address
// bus_op             out   8    opcode
// bus_data           out   32   payload
// bus_valid          out   1    command presented to the targets
// bus_ack            in    1    target accepted; the transfer completes when valid & ack
// busy               out   1    high in every state except IDLE
// timeout_err        out   1    sticky; set on an ack timeout, cleared only by rst
// issued_count       out   CNT_W  number of completed handshakes, wraps at 2^CNT_W
//
// BEHAVIOUR
// - Command word layout:
//   [79:48] start_time   [47:40] addr   [39:32] op   [31:0] data
//   start_time == 0 means "issue immediately".
// - Reset values: every output is 0; state = IDLE; the latched command register is 0.
// - States and transitions:
//   IDLE   : !cmd_fifo_empty -> FETCH.
//   FETCH  : cmd_fifo_rd_en = 1 for this cycle only -> LATCH.
//   LATCH  : capture cmd_fifo_data_out into the command register -> WAIT.
//   WAIT   : (start_time == 0 || global_clock >= start_time) -> ISSUE; otherwise stay.
//            The compare is unsigned with no wrap handling.
//            If time is stopped or reset, WAIT holds indefinitely until flush.
//   ISSUE  : bus_valid = 1; bus_addr/op/data are driven from the register and held
//            stable for the whole of ISSUE.
//            - bus_ack -> issued_count++, go to IDLE.
//            - Timeout counter reaches ACK_TIMEOUT-1 without ack -> set timeout_err,
//              drop the command, go to IDLE.
// - Outputs and flags:
//   bus_valid is registered, so it is high exactly while the state is ISSUE.
//   bus_addr/op/data keep their last value outside ISSUE.
//   busy = (state != IDLE).
// - Latency: empty falls at cycle n (IDLE) -> rd_en at n+1 -> bus_valid first high at
//   n+4 when the command is due; best case is one command per 5 cycles.
// - flush: takes priority in every state and returns to IDLE on the next edge.
//   - A popped command is discarded; the FIFO itself is untouched.
//   - If flush and bus_ack coincide in ISSUE, the handshake counts: issued_count
//     increments.
//   - A flush during FETCH still consumes the word; it is discarded.
// - rst mid-operation: returns to IDLE immediately and clears all outputs, including
//   timeout_err and issued_count.
// - No pop is issued while busy, so there is at most one command in flight.
// - cmd_fifo_empty is not re-sampled after FETCH.
// - bus_ack outside ISSUE is ignored.
// - ACK_TIMEOUT == 0: ISSUE waits indefinitely for ack or flush.
// - The timeout counter is ceil(log2(ACK_TIMEOUT+1)) bits, cleared on entry to ISSUE.
//
// STRUCTURE
// - Shared package mecobo_cmd_pkg holds:
//   - field offsets and widths (CMD_TIME_HI/LO, CMD_ADDR_HI/LO, CMD_OP_HI/LO,
//     CMD_DATA_HI/LO, CMD_W = 80);
//   - opcode constants;
//   - the state encoding localparams.
// - Single module: FSM plus command register, timeout counter and issue counter.
//   No sub-module.
//
// TESTING
// 1. Immediate issue:
//    push {32'h0, 8'h03, 8'h01, 32'hCAFEF00D} -> rd_en pulses 1 cycle; bus_valid at
//    n+4 with addr=03 op=01 data=CAFEF00D; ack 2 cycles later -> issued_count=1, IDLE.
// 2. Timed issue:
//    global_clock running from 0, start_time=100 -> bus_valid rises the cycle after
//    global_clock==100 and not before.
// 3. Back-to-back:
//    3 commands queued, immediate ack -> 3 separate rd_en pulses at least 5 cycles
//    apart; issued_count=3; commands leave in FIFO order.
// 4. Timeout:
//    ACK_TIMEOUT=8, no ack -> bus_valid high exactly 8 cycles; timeout_err=1 and
//    stays 1; the next command still issues.
// 5. Flush:
//    flush while waiting on start_time=1000 -> IDLE next cycle, no bus_valid,
//    issued_count unchanged.
//    flush coincident with ack -> issued_count increments.
// 6. Reset mid-ISSUE:
//    rst pulsed with bus_valid high -> next cycle all outputs 0; timeout_err and
//    issued_count are 0.

Source files
------------

// File: rtl/mecobo_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mecobo_cmd_pkg
// Purpose  : Shared command-word layout, opcodes and dispatcher state
//            encoding for the EBI command path.
// Revision : 1.0 - initial release
// ============================================================================
package mecobo_cmd_pkg;

   // Command word layout: {start_time, addr, op, data}
   localparam int CMD_W       = 80;
   localparam int CMD_TIME_HI = 79;
   localparam int CMD_TIME_LO = 48;
   localparam int CMD_ADDR_HI = 47;
   localparam int CMD_ADDR_LO = 40;
   localparam int CMD_OP_HI   = 39;
   localparam int CMD_OP_LO   = 32;
   localparam int CMD_DATA_HI = 31;
   localparam int CMD_DATA_LO = 0;

   // Opcodes understood by the control-bus targets
   localparam logic [7:0] OP_NOP   = 8'h00;
   localparam logic [7:0] OP_WRITE = 8'h01;
   localparam logic [7:0] OP_READ  = 8'h02;
   localparam logic [7:0] OP_RESET = 8'h03;

   // Dispatcher state encoding
   localparam logic [2:0] ST_ENC_IDLE  = 3'd0;
   localparam logic [2:0] ST_ENC_FETCH = 3'd1;
   localparam logic [2:0] ST_ENC_LATCH = 3'd2;
   localparam logic [2:0] ST_ENC_WAIT  = 3'd3;
   localparam logic [2:0] ST_ENC_ISSUE = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = ST_ENC_IDLE,
      ST_FETCH = ST_ENC_FETCH,
      ST_LATCH = ST_ENC_LATCH,
      ST_WAIT  = ST_ENC_WAIT,
      ST_ISSUE = ST_ENC_ISSUE
   } disp_state_t;

   // A command is due when it has no start time or the time base has reached it.
   // Plain unsigned compare: a wrapped time base is not handled.
   function automatic logic cmd_due(input logic [31:0] start_time,
                                    input logic [31:0] now);
      return (start_time == 32'd0) || (now >= start_time);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : cmd_dispatcher
// Purpose  : Pops timed commands from the EBI command FIFO, holds each one
//            until its start time and issues it on the control bus with a
//            valid/ack handshake. Sticky ack-timeout flag and issue counter.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_dispatcher
   import mecobo_cmd_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 1024,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       global_clock,
   input  logic [CMD_W-1:0]  cmd_fifo_data_out,
   input  logic              cmd_fifo_empty,
   output logic              cmd_fifo_rd_en,
   input  logic              flush,
   output logic [7:0]        bus_addr,
   output logic [7:0]        bus_op,
   output logic [31:0]       bus_data,
   output logic              bus_valid,
   input  logic              bus_ack,
   output logic              busy,
   output logic              timeout_err,
   output logic [CNT_W-1:0]  issued_count
);

   // Timeout counter must hold ACK_TIMEOUT-1; keep at least one bit when disabled
   localparam int unsigned     TO_W    = (ACK_TIMEOUT == 0) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

   disp_state_t        state_q;
   logic [CMD_W-1:0]   cmd_q;
   logic [TO_W-1:0]    to_cnt_q;
   logic [TO_W-1:0]    to_cnt_d;
   logic [CNT_W-1:0]   issued_q;
   logic [CNT_W-1:0]   issued_d;
   logic               err_q;
   logic               rd_en_q;
   logic               valid_q;
   logic [7:0]         addr_q;
   logic [7:0]         op_q;
   logic [31:0]        data_q;
   logic               due_d;
   logic               ack_hit_d;

   assign to_cnt_d  = to_cnt_q + 1'b1;
   assign issued_d  = issued_q + 1'b1;
   assign due_d     = cmd_due(cmd_q[CMD_TIME_HI:CMD_TIME_LO], global_clock);
   assign ack_hit_d = (state_q == ST_ISSUE) && bus_ack;

   // Dispatcher FSM with registered strobe, bus drive, timeout and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cmd_q    <= '0;
         to_cnt_q <= '0;
         issued_q <= '0;
         err_q    <= 1'b0;
         rd_en_q  <= 1'b0;
         valid_q  <= 1'b0;
         addr_q   <= '0;
         op_q     <= '0;
         data_q   <= '0;
      end else begin
         rd_en_q <= 1'b0;
         if (flush) begin
            // Abort whatever is pending; an ack landing in the same cycle still counts
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            if (ack_hit_d) begin
               issued_q <= issued_d;
            end
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (!cmd_fifo_empty) begin
                     state_q <= ST_FETCH;
                     rd_en_q <= 1'b1;
                  end
               end
               ST_FETCH: begin
                  state_q <= ST_LATCH;
               end
               ST_LATCH: begin
                  cmd_q   <= cmd_fifo_data_out;
                  state_q <= ST_WAIT;
               end
               ST_WAIT: begin
                  if (due_d) begin
                     state_q  <= ST_ISSUE;
                     valid_q  <= 1'b1;
                     to_cnt_q <= '0;
                     addr_q   <= cmd_q[CMD_ADDR_HI:CMD_ADDR_LO];
                     op_q     <= cmd_q[CMD_OP_HI:CMD_OP_LO];
                     data_q   <= cmd_q[CMD_DATA_HI:CMD_DATA_LO];
                  end
               end
               ST_ISSUE: begin
                  if (bus_ack) begin
                     issued_q <= issued_d;
                     valid_q  <= 1'b0;
                     state_q  <= ST_IDLE;
                  end else if ((ACK_TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
                     err_q   <= 1'b1;
                     valid_q <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     to_cnt_q <= to_cnt_d;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  valid_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign cmd_fifo_rd_en = rd_en_q;
   assign bus_valid      = valid_q;
   assign bus_addr       = addr_q;
   assign bus_op         = op_q;
   assign bus_data       = data_q;
   assign busy           = (state_q != ST_IDLE);
   assign timeout_err    = err_q;
   assign issued_count   = issued_q;

endmodule
`default_nettype wire
